// File: rtl/alert_scheduler.sv
// Purpose: arbitrates countdown and alarm ring requests onto one buzzer, with alarm snooze.
// Latency: events and button edges act on the next clock edge; all outputs are registered.
// Backpressure: none; requests that arrive while busy are held in pending flags or ignored.
module alert_scheduler #(
   parameter int TICK_DIV     = 12500000,
   parameter int RING_TICKS   = 240,
   parameter int SNOOZE_TICKS = 1200
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_cdwn,
   input  logic       req_alarm,
   input  logic       ack,
   input  logic       snooze,
   output logic       buzz,
   output logic [1:0] active_src,
   output logic       snoozing
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int RW = $clog2(RING_TICKS) + 1;
   localparam int SW = $clog2(SNOOZE_TICKS) + 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [RW-1:0] RING_LIM = RW'(RING_TICKS);
   localparam logic [SW-1:0] SNZ_LIM  = SW'(SNOOZE_TICKS);

   // State encoding doubles as the active_src output.
   typedef enum logic [1:0] {
      IDLE       = 2'b00,
      RING_CDWN  = 2'b01,
      RING_ALARM = 2'b10,
      SNOOZE     = 2'b11
   } state_t;

   state_t          state_q;
   logic [PW-1:0]   pre_q, pre_d;
   logic [RW-1:0]   ring_cnt_q, ring_inc_d;
   logic [SW-1:0]   snz_cnt_q, snz_inc_d;
   logic            buzz_q, snoozing_q;
   logic            pend_cdwn_q, pend_alarm_q;
   logic            cdwn_prev_q, ack_prev_q, snooze_prev_q;
   logic            tick;
   logic            cdwn_edge, ack_edge, snooze_edge;
   logic            alarm_ev, cdwn_ev, ring_end, snz_end;

   assign tick        = (pre_q == PRE_LAST);
   assign cdwn_edge   = req_cdwn & ~cdwn_prev_q;
   assign ack_edge    = ack & ~ack_prev_q;
   assign snooze_edge = snooze & ~snooze_prev_q;
   assign alarm_ev    = pend_alarm_q | req_alarm;
   assign cdwn_ev     = pend_cdwn_q | cdwn_edge;

   // Next values for the prescaler and the saturating tick counters.
   always_comb begin
      pre_d      = tick ? '0 : pre_q + PW'(1);
      ring_inc_d = (ring_cnt_q == RING_LIM) ? ring_cnt_q : ring_cnt_q + RW'(1);
      snz_inc_d  = (snz_cnt_q == SNZ_LIM) ? snz_cnt_q : snz_cnt_q + SW'(1);
   end

   // A ring stops on the ack edge or on the tick that brings the count to its limit.
   assign ring_end = ack_edge | (tick & (ring_inc_d == RING_LIM));
   assign snz_end  = tick & (snz_inc_d == SNZ_LIM);

   // Free-running prescaler and previous-value flops for the edge detectors.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_q         <= '0;
         cdwn_prev_q   <= 1'b0;
         ack_prev_q    <= 1'b0;
         snooze_prev_q <= 1'b0;
      end else begin
         pre_q         <= pre_d;
         cdwn_prev_q   <= req_cdwn;
         ack_prev_q    <= ack;
         snooze_prev_q <= snooze;
      end
   end

   // Scheduler FSM; buzz and snoozing are registered alongside the state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         buzz_q       <= 1'b0;
         snoozing_q   <= 1'b0;
         ring_cnt_q   <= '0;
         snz_cnt_q    <= '0;
         pend_cdwn_q  <= 1'b0;
         pend_alarm_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (alarm_ev) begin
                  state_q      <= RING_ALARM;
                  buzz_q       <= 1'b1;
                  ring_cnt_q   <= '0;
                  pend_alarm_q <= 1'b0;
                  pend_cdwn_q  <= cdwn_ev;
               end else if (cdwn_ev) begin
                  state_q     <= RING_CDWN;
                  buzz_q      <= 1'b1;
                  ring_cnt_q  <= '0;
                  pend_cdwn_q <= 1'b0;
               end
            end
            RING_CDWN: begin
               if (ring_end) begin
                  ring_cnt_q <= '0;
                  if (snoozing_q) begin
                     // Countdown interrupted a snooze: resume it; the alarm is already snoozed.
                     state_q      <= SNOOZE;
                     buzz_q       <= 1'b0;
                     pend_alarm_q <= 1'b0;
                  end else if (alarm_ev) begin
                     state_q      <= RING_ALARM;
                     buzz_q       <= 1'b1;
                     pend_alarm_q <= 1'b0;
                  end else begin
                     state_q <= IDLE;
                     buzz_q  <= 1'b0;
                  end
               end else begin
                  if (req_alarm) pend_alarm_q <= 1'b1;
                  if (tick) begin
                     buzz_q     <= ~buzz_q;
                     ring_cnt_q <= ring_inc_d;
                  end
               end
            end
            RING_ALARM: begin
               if (ring_end) begin
                  ring_cnt_q <= '0;
                  if (cdwn_ev) begin
                     state_q     <= RING_CDWN;
                     buzz_q      <= 1'b1;
                     pend_cdwn_q <= 1'b0;
                  end else begin
                     state_q <= IDLE;
                     buzz_q  <= 1'b0;
                  end
               end else if (snooze_edge) begin
                  state_q    <= SNOOZE;
                  buzz_q     <= 1'b0;
                  snoozing_q <= 1'b1;
                  snz_cnt_q  <= '0;
                  if (cdwn_edge) pend_cdwn_q <= 1'b1;
               end else begin
                  if (cdwn_edge) pend_cdwn_q <= 1'b1;
                  if (tick) begin
                     buzz_q     <= ~buzz_q;
                     ring_cnt_q <= ring_inc_d;
                  end
               end
            end
            SNOOZE: begin
               if (ack_edge) begin
                  state_q    <= IDLE;
                  snoozing_q <= 1'b0;
                  snz_cnt_q  <= '0;
               end else if (cdwn_ev) begin
                  // Snooze count stays frozen while the countdown rings.
                  state_q     <= RING_CDWN;
                  buzz_q      <= 1'b1;
                  ring_cnt_q  <= '0;
                  pend_cdwn_q <= 1'b0;
               end else if (snz_end) begin
                  state_q    <= RING_ALARM;
                  buzz_q     <= 1'b1;
                  ring_cnt_q <= '0;
                  snoozing_q <= 1'b0;
                  snz_cnt_q  <= '0;
               end else if (tick) begin
                  snz_cnt_q <= snz_inc_d;
               end
            end
         endcase
      end
   end

   assign buzz       = buzz_q;
   assign active_src = state_q;
   assign snoozing   = snoozing_q;
endmodule

// File: doc/alert_scheduler.md
ALERT_SCHEDULER -- requirements
Module: alert_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 12500000, clk cycles per beat tick (4 Hz at 50 MHz).
REQ-002 Parameter RING_TICKS, default 240, beat ticks before an unacknowledged ring auto-stops (60 s).
REQ-003 Parameter SNOOZE_TICKS, default 1200, beat ticks in one snooze interval (300 s).
REQ-004 clk  in  1  system clock (CLOCK_50); single clock domain.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_cdwn  in  1  level, countdown timer at zero; only its rising edge raises a countdown event.
REQ-007 req_alarm  in  1  one-cycle pulse, clock time equals alarm time.
REQ-008 ack  in  1  level, acknowledge button (pressed = 1); rising edge used.
REQ-009 snooze  in  1  level, snooze button (pressed = 1); rising edge used.
REQ-010 buzz  out  1  buzzer/LED drive.
REQ-011 active_src  out  2  00 idle, 01 countdown ringing, 10 alarm ringing, 11 alarm snoozed.
REQ-012 snoozing  out  1  high while a snooze interval is held (running or frozen).

Function
REQ-013 Free-running prescaler; tick = one-cycle strobe every TICK_DIV cycles; not reset by state changes.
REQ-014 Edge detectors on req_cdwn, ack and snooze: one registered previous-value flop each; edge = in & ~prev.
REQ-015 States: IDLE, RING_CDWN, RING_ALARM, SNOOZE; active_src encodes state (IDLE=00, RING_CDWN=01, RING_ALARM=10, SNOOZE=11).
REQ-016 pend_cdwn, pend_alarm flags latch events not yet served; cleared when served.
REQ-017 Priority: alarm over countdown; same-cycle events -> RING_ALARM next cycle, pend_cdwn set.
REQ-018 IDLE: pend_alarm or req_alarm -> RING_ALARM; else pend_cdwn or req_cdwn edge -> RING_CDWN.
REQ-019 On entry to any RING state: ring counter = 0, buzz = 1 in the first ringing cycle.
REQ-020 In RING states buzz toggles on each tick; ring counter increments on each tick.
REQ-021 Ring ends on ack edge (registered, next cycle) or when ring counter reaches RING_TICKS; buzz = 0 once ended.
REQ-022 RING_CDWN end -> SNOOZE if snooze frozen (REQ-025), else RING_ALARM if pend_alarm, else IDLE.
REQ-023 RING_ALARM end -> RING_CDWN if pend_cdwn, else IDLE; snooze edge in RING_ALARM -> SNOOZE, snooze counter = 0.
REQ-024 SNOOZE: buzz = 0, snoozing = 1, snooze counter increments per tick; at SNOOZE_TICKS -> RING_ALARM (fresh ring); ack edge -> IDLE, snooze cancelled.
REQ-025 SNOOZE with countdown event (pending or edge) -> RING_CDWN; snooze counter frozen, snoozing stays 1; resumes counting on return.
REQ-026 req_alarm in RING_ALARM or SNOOZE ignored; in RING_CDWN sets pend_alarm.
REQ-027 req_cdwn edge in RING_CDWN ignored; in RING_ALARM sets pend_cdwn.
REQ-028 ack and snooze edges in the same cycle: ack wins.
REQ-029 Held req_cdwn after ring end causes no re-ring until it falls and rises again.
REQ-030 Counter widths = $clog2 of respective limits + 1; no wrap: counters saturate at limit.

Reset
REQ-031 reset_n low, any time: state IDLE, buzz 0, active_src 00, snoozing 0, all counters, pending flags and edge-detector flops 0, within the same edge (asynchronous).
REQ-032 Edge flops reset to 0: input already high at release registers an edge in the first cycle.
REQ-033 Reset mid-ring or mid-snooze discards all pending events.

Verification (TICK_DIV=4, RING_TICKS=8, SNOOZE_TICKS=6)
REQ-034 req_cdwn 0->1 from IDLE -> active_src 01, buzz 1, toggles every 4 cycles, IDLE with buzz 0 after 8 ticks; req_cdwn held 1 -> stays IDLE.
REQ-035 req_alarm and req_cdwn edge same cycle -> active_src 10; ack edge -> 01 next cycle; after ack again -> 00.
REQ-036 Alarm ringing, snooze edge -> 11, buzz 0, snoozing 1; 6 ticks later -> 10, buzz 1, snoozing 0.
REQ-037 In SNOOZE after 3 ticks, req_cdwn edge -> 01 with snoozing 1; ack -> 11, alarm rings after 3 further ticks.
REQ-038 reset_n low during RING_ALARM with pend_cdwn set -> buzz 0, active_src 00 immediately; after release with inputs low, stays IDLE.
